// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the producers, the round-robin arbiter and the FIFO write pins.
// master = producers/FIFO-flag side, slave = arbiter side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic                      fifo_full;
  logic                      fifo_write;
  logic [DATA_W-1:0]         fifo_data_in;
  logic                      burst_active;
  logic [IW-1:0]             owner;

  modport master (
    output req, req_lock, req_data, fifo_full,
    input  gnt, fifo_write, fifo_data_in, burst_active, owner
  );

  modport slave (
    input  req, req_lock, req_data, fifo_full,
    output gnt, fifo_write, fifo_data_in, burst_active, owner
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with locked bursts of up to MAX_BURST words and a hard no-write-when-full guard.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
  localparam logic [IW:0]   NUM_REQ_W = (IW + 1)'(NUM_REQ);
  localparam logic [CW-1:0] BEAT_MAX  = CW'(MAX_BURST);
  localparam bit            BURST_EN  = (MAX_BURST > 1);

  logic [0:0]        state_reg, state_next;
  logic [IW-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]     owner_reg, owner_next;
  logic [CW-1:0]     beat_cnt_reg, beat_cnt_next;
  logic [CW-1:0]     beat_inc;

  logic [DATA_W-1:0] data_arr [NUM_REQ];
  logic [IW-1:0]     cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_req;

  logic              found;
  logic [IW-1:0]     winner;
  logic [IW-1:0]     sel_idx;
  logic              sel_valid;
  logic              accept;

  // Candidate gi is the requester gi places after rr_ptr, wrapping modulo NUM_REQ.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IW:0] sum;
      assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
      assign sum          = {1'b0, rr_ptr_reg} + (IW + 1)'(gi);
      assign cand_idx[gi] = (sum >= NUM_REQ_W) ? IW'(sum - NUM_REQ_W) : IW'(sum);
      assign cand_req[gi] = bus.req[cand_idx[gi]];
    end
  endgenerate

  // Scan from the far end so the closest candidate to rr_ptr is written last and wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        found  = 1'b1;
        winner = cand_idx[k];
      end
    end
  end

  assign sel_idx   = (state_reg == BURST) ? owner_reg : winner;
  assign sel_valid = (state_reg == BURST) ? bus.req[owner_reg] : found;
  // rst gates the grant combinationally so outputs drop the instant reset rises.
  assign accept    = sel_valid & ~bus.fifo_full & ~rst;

  assign bus.gnt          = accept ? (NUM_REQ'(1) << sel_idx) : '0;
  assign bus.fifo_write   = accept;
  assign bus.fifo_data_in = accept ? data_arr[sel_idx] : '0;
  assign bus.burst_active = (state_reg == BURST);
  assign bus.owner        = owner_reg;

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    owner_next    = owner_reg;
    beat_cnt_next = beat_cnt_reg;
    beat_inc      = beat_cnt_reg + CW'(1);

    if (state_reg == IDLE) begin
      if (accept) begin
        rr_ptr_next = (winner == LAST_IDX) ? '0 : winner + IW'(1);
        owner_next  = winner;
        if (BURST_EN && bus.req_lock[winner]) begin
          state_next    = BURST;
          beat_cnt_next = CW'(1);
        end
      end
    end else begin
      if (!bus.req[owner_reg]) begin
        // Owner walked away: burn this cycle and fall back to round-robin.
        state_next    = IDLE;
        beat_cnt_next = '0;
      end else if (accept) begin
        if (!bus.req_lock[owner_reg] || (beat_inc == BEAT_MAX)) begin
          state_next    = IDLE;
          beat_cnt_next = '0;
        end else begin
          beat_cnt_next = beat_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      owner_reg    <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      owner_reg    <= owner_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic,
// all checked against a rule-level reference model of the arbitration.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [W-1:0]   data [N];
  logic           full;
  logic [N*W-1:0] data_flat;

  logic [N-1:0]   obs_gnt;
  logic           obs_write;
  logic [W-1:0]   obs_data;

  int checks = 0;
  int errors = 0;

  int m_ptr, m_owner, m_beats;
  bit m_burst;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign data_flat[gi*W +: W] = data[gi];
    end
  endgenerate

  assign bus.req       = req;
  assign bus.req_lock  = lock;
  assign bus.req_data  = data_flat;
  assign bus.fifo_full = full;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_owner = 0;
    m_beats = 0;
    m_burst = 0;
  endtask

  // Who should be written this cycle, or -1 for nobody.
  function automatic int exp_winner();
    if (full || rst) return -1;
    if (m_burst) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Inputs are already driven just after a negedge; check, clock, update model.
  task automatic step(input string tag, output int g);
    int w;
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    #1;
    w  = exp_winner();
    eg = (w < 0) ? '0 : (N'(1) << w);
    ed = (w < 0) ? '0 : data[w];
    obs_gnt   = bus.gnt;
    obs_write = bus.fifo_write;
    obs_data  = bus.fifo_data_in;
    chk({tag, "_gnt"},   32'(obs_gnt),          32'(eg));
    chk({tag, "_write"}, 32'(obs_write),        32'(w >= 0));
    chk({tag, "_data"},  32'(obs_data),         32'(ed));
    chk({tag, "_burst"}, 32'(bus.burst_active), 32'(m_burst));
    chk({tag, "_owner"}, 32'(bus.owner),        32'(m_owner));
    $display("%0t %s req=%b lock=%b full=%b gnt=%b data=%h", $time, tag, req, lock, full, obs_gnt, obs_data);
    @(posedge clk);
    if (m_burst) begin
      if (!req[m_owner]) begin
        m_burst = 0; m_beats = 0;
      end else if (w >= 0) begin
        m_beats++;
        if (!lock[m_owner] || m_beats == MB) begin
          m_burst = 0; m_beats = 0;
        end
      end
    end else if (w >= 0) begin
      m_ptr   = (w + 1) % N;
      m_owner = w;
      if (lock[w] && MB > 1) begin
        m_burst = 1; m_beats = 1;
      end
    end
    g = w;
    @(negedge clk);
  endtask

  initial begin
    int g, occ, writes, word;
    logic [W-1:0] last_data;

    rst  = 1'b1;
    req  = '1;
    lock = '1;
    full = 1'b0;
    for (int i = 0; i < N; i++) data[i] = W'(16'hA0 + i);
    model_reset();
    #1;
    chk("rst_gnt",   32'(bus.gnt),          0);
    chk("rst_write", 32'(bus.fifo_write),   0);
    chk("rst_data",  32'(bus.fifo_data_in), 0);
    chk("rst_burst", 32'(bus.burst_active), 0);
    chk("rst_owner", 32'(bus.owner),        0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fairness: all four requesting, no locks.
    req = 4'b1111; lock = '0;
    for (int k = 0; k < 5; k++) begin
      step("fair", g);
      chk("fair_seq", 32'(obs_gnt), 32'(1 << (k % 4)));
    end

    // Burst cap with rr_ptr at 1.
    req = 4'b0111; lock = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      step("cap", g);
      chk("cap_seq", 32'(obs_gnt), 32'h2);
    end
    req[1] = 1'b0; lock = '0;
    step("cap_next", g);
    chk("cap_seq2", 32'(obs_gnt), 32'h4);
    req[2] = 1'b0;
    step("cap_next", g);
    chk("cap_seq0", 32'(obs_gnt), 32'h1);
    req = '0;

    // Full stall in the middle of a locked burst.
    req = 4'b0001; lock = 4'b0001;
    step("stall_b1", g);
    step("stall_b2", g);
    full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step("stall_full", g);
      chk("stall_nowrite", 32'(obs_write), 0);
    end
    full = 1'b0;
    step("stall_b3", g);
    chk("stall_b3_gnt", 32'(obs_gnt), 32'h1);
    step("stall_b4", g);
    chk("stall_b4_gnt", 32'(obs_gnt), 32'h1);
    req = '0; lock = '0;
    step("stall_idle", g);

    // Owner drops after one beat while req3 waits.
    req = 4'b0001; lock = 4'b0001;
    step("drop_b1", g);
    req = 4'b1000; lock = '0;
    step("drop_gap", g);
    chk("drop_gap_gnt", 32'(obs_gnt), 0);
    step("drop_r3", g);
    chk("drop_r3_gnt", 32'(obs_gnt), 32'h8);
    req = '0;

    // Asynchronous reset at beat 2 of a burst.
    req = 4'b0001; lock = 4'b0001; data[0] = 16'h1234;
    step("rstb_b1", g);
    step("rstb_b2", g);
    #2 rst = 1'b1;
    #1;
    chk("rstb_gnt",   32'(bus.gnt),          0);
    chk("rstb_write", 32'(bus.fifo_write),   0);
    chk("rstb_burst", 32'(bus.burst_active), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0; req = 4'b0100; lock = '0;
    step("rstb_after", g);
    chk("rstb_after_gnt", 32'(obs_gnt), 32'h4);
    req = '0;

    // Overflow guard against a 16-deep FIFO with no reads.
    occ = 0; writes = 0; word = 1; last_data = '0;
    req = 4'b0001; lock = '0; data[0] = W'(word);
    for (int c = 0; c < 24; c++) begin
      full = (occ >= 16);
      step("ovf", g);
      chk("ovf_guard", 32'(obs_write & full), 0);
      if (obs_write) begin
        occ++; writes++; last_data = obs_data;
      end
      if (obs_gnt[0]) begin
        if (word < 20) begin
          word++; data[0] = W'(word);
        end else begin
          req[0] = 1'b0;
        end
      end
    end
    chk("ovf_writes",  32'(writes),    16);
    chk("ovf_last",    32'(last_data), 16);
    chk("ovf_pending", 32'(req[0]),    1);
    req = '0; full = 1'b0;
    step("ovf_idle", g);

    // Randomized traffic: hold each word until granted.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          req[i]  = 1'b1;
          data[i] = W'($urandom);
          lock[i] = ($urandom_range(0, 1) == 1);
        end
      end
      full = ($urandom_range(0, 4) == 0);
      step("rand", g);
      for (int i = 0; i < N; i++) begin
        if (obs_gnt[i]) req[i] = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that lets several producers share the single write port of one `fifo` instance. It sits between the requesters and the FIFO's `fifo_write`/`fifo_data_in`/`fifo_full` pins. It supports locked bursts, so one producer can push up to `MAX_BURST` consecutive words without interleaving. It never issues a write while the FIFO reports full.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `DATA_W`, default 16: data width; matches the FIFO data width.
- `MAX_BURST`, default 4: maximum words per locked burst, ≥1.
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NUM_REQ  per-requester write request; held with data until granted.
- `req_lock`  in  NUM_REQ  per-requester burst hint; sampled on an accepted beat.
- `req_data`  in  NUM_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W].
- `gnt`  out  NUM_REQ  one-hot; `gnt[i]`=1 means req i's word is written at this posedge.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_write`  out  1  FIFO write strobe.
- `fifo_data_in`  out  DATA_W  FIFO write data.
- `burst_active`  out  1  high while in BURST state (registered).
- `owner`  out  $clog2(NUM_REQ)  current/last burst owner index (registered).

## Operation
- State registers:
  - `state` ∈ {IDLE, BURST}.
  - `rr_ptr` (requester index with highest priority).
  - `owner`.
  - `beat_cnt` ($clog2(MAX_BURST+1) bits).
- Reset values: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, burst_active=0. While rst=1: gnt=0, fifo_write=0, fifo_data_in=0.
- `fifo_write` = |gnt. `fifo_data_in` = data of the granted requester, 0 when no grant.
- A grant requires `fifo_full`=0. When full, no gnt and no write, in any state.
- IDLE behaviour:
  - Winner = first i with req[i]=1, searching rr_ptr, rr_ptr+1, … with wrap modulo NUM_REQ.
  - If a winner exists and the FIFO is not full, gnt[winner]=1.
  - On an accepted beat: rr_ptr ← (winner+1) mod NUM_REQ and owner ← winner.
  - If req_lock[winner]=1 and MAX_BURST>1: go to BURST with beat_cnt ← 1. Otherwise stay IDLE.
- BURST behaviour:
  - Only `owner` can be granted. Other requests are ignored.
  - If req[owner]=1 and not full: gnt[owner]=1 and beat_cnt increments.
  - Return to IDLE after an accepted beat with req_lock[owner]=0, or after the beat that makes beat_cnt=MAX_BURST.
  - If req[owner]=0: no grant that cycle, and return to IDLE at the next edge.
  - If full with req[owner]=1: stall in BURST and hold beat_cnt. There is no timeout.
- rr_ptr does not change during BURST. The owner's successor has top priority once the arbiter is back in IDLE.
- beat_cnt is cleared on every transition to IDLE.

## Timing
- Zero-cycle grant latency: gnt, fifo_write and fifo_data_in are combinational from req, req_data, fifo_full and the registered state.
- Throughput is one word per cycle, including back-to-back grants to different requesters in IDLE.
- Requesters must keep req and req_data stable until they see gnt. A requester may drop req only after a granted cycle.
- A burst ending by owner drop costs exactly one idle cycle. A burst ending on the MAX_BURST beat or on an unlocked beat costs none.
- Asynchronous rst mid-burst: outputs go to their reset values immediately. The word being written in that cycle is not guaranteed; the requester still sees it as ungranted.
- burst_active and owner change only on posedge or on rst.

## Test plan
1. **Reset mid-burst.** Assert rst while req0 is locked in BURST at beat 2 → gnt=0, fifo_write=0, burst_active=0 immediately. After release, req2 alone is granted first cycle.
2. **Fairness.** req=4'b1111 with no lock, FIFO not empty-limited → gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles; fifo_data_in tracks each requester.
3. **Burst cap.** req=4'b0111, req_lock[1]=1, rr_ptr=1, MAX_BURST=4 → gnt[1] for 4 consecutive cycles, then gnt[2], then gnt[0].
4. **Full stall.** req0 locked burst; fifo_full=1 for 3 cycles after beat 2 → gnt=0 and fifo_write=0 for those cycles, beat_cnt held at 2. Then beats 3–4 are granted to req0, followed by IDLE.
5. **Owner drop.** Owner drops req after beat 1 of a locked burst with req3 pending → one cycle with gnt=0, then gnt[3].
6. **Overflow guard with `fifo` (depth 16).** Single requester presents words 1..20, no reads → exactly 16 writes with data 1..16, fifo_write never high while fifo_full=1, req stays pending.
